// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//   Serial-to-parallel frame receiver. Waits for a start bit (sin=0) on a
//   bit strobe, shifts in WIDTH data bits LSB-first or MSB-first, checks the
//   stop bit and presents the word on dout with a one-cycle dout_valid pulse.
//   A bad stop bit pulses frame_err and parks the receiver in BREAK until the
//   line returns high.
//
//   Optional feature macro: SERIAL_FRAME_RX_PARITY_EN
//     When defined, an even-parity bit follows the data bits. A mismatch
//     pulses parity_err on the stop-bit edge. When undefined, parity_err is
//     tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   bit strobe; sin is sampled only when en=1
//   sin        in   serial data, idles high
//   msb_first  in   bit order, captured at start-bit detection
//   dout       out  last correctly framed word
//   dout_valid out  one-cycle pulse when dout updates
//   frame_err  out  one-cycle pulse on a bad stop bit
//   parity_err out  one-cycle pulse on parity mismatch (0 without the macro)
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
            dir_d   = msb_first;
          end
        end

        S_DATA: begin
          if (dir_q)
            shreg_d = {shreg_q[WIDTH-2:0], sin};
          else
            shreg_d = {sin, shreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          // cnt_q still holds the count before this bit, so WIDTH-1 marks
          // the last data bit of the frame.
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end

`ifdef SERIAL_FRAME_RX_PARITY_EN
        S_PARITY: begin
          par_d   = sin;
          state_d = S_STOP;
        end
`endif

        S_STOP: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          // Even parity: parity bit together with data must XOR to 0.
          parity_err_d = par_q ^ (^shreg_q);
`endif
          if (sin) begin
            dout_d       = shreg_q;
            dout_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end

        S_BREAK: begin
          // The high sample that ends the break is consumed here, so it can
          // never be mistaken for part of the next frame.
          if (sin) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver; the receiving end of the serial stream produced by the team's universal shift register in parallel-load/shift-out mode.
- Detects a start bit, shifts in WIDTH data bits LSB-first or MSB-first, checks the stop bit, and presents the word on a parallel bus with a one-cycle valid strobe.
- Sits between a bit-rate strobe source and downstream parallel logic.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  bit strobe; sin is sampled only on clk edges where en=1.
- sin  input  1  serial data in; line idles high.
- msb_first  input  1  0 = LSB-first, 1 = MSB-first; captured at start-bit detection.
- dout  output  WIDTH  last correctly framed word.
- dout_valid  output  1  one-cycle pulse when dout updates.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 unless the macro is defined.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, shift register=0, bit counter=0, dout=0, dout_valid=0, frame_err=0, parity_err=0, busy=0. Reset mid-frame discards the partial frame immediately.
- en=0: all state holds; the strobe outputs are 0 that cycle. sin activity while en=0 is ignored.
- Strobes: dout_valid, frame_err and parity_err are registered and last exactly one clk cycle, then return to 0.
- IDLE:
  - en=1 and sin=0: go to DATA, clear counter, latch msb_first into dir_r.
  - en=1 and sin=1: stay in IDLE.
- DATA: on each en=1, shift one bit in.
  - LSB-first: shreg <= {sin, shreg[WIDTH-1:1]}.
  - MSB-first: shreg <= {shreg[WIDTH-2:0], sin}.
  - Counter increments on each shifted bit; it is clog2(WIDTH)+1 bits wide with no wrap inside a frame.
  - After the WIDTH-th bit, go to PARITY (macro defined) or STOP.
- dir_r is fixed for the whole frame; changing msb_first mid-frame has no effect.
- STOP, on en=1:
  - sin=1: dout <= shreg, pulse dout_valid, go to IDLE.
  - sin=0: pulse frame_err, leave dout unchanged, go to BREAK.
- BREAK: stay until en=1 with sin=1, then go to IDLE. The sin=1 sample is consumed and is not a start bit.
- Back-to-back frames: a start bit on the first en after a good stop is accepted. With en=1 every cycle, the minimum frame is WIDTH+2 cycles.
- Latency: dout/dout_valid update on the same edge that samples the stop bit. They are visible in the cycle after that edge.
- busy=1 in DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; on en=1 it samples an even-parity bit.
  - Expected parity bit = XOR of the WIDTH data bits.
  - On a mismatch, parity_err pulses on the stop-bit edge, in the same cycle as dout_valid or frame_err. dout still updates if the stop bit is good.
  - Minimum frame becomes WIDTH+3 cycles.
- Undefined: no PARITY state and parity_err is constant 0.

Test Plan:
1. WIDTH=8, en=1 every cycle, msb_first=0, sin sequence 0,1,0,1,0,0,1,0,1,1 -> dout=8'hA5 and dout_valid high for exactly one cycle, 10 cycles after the start bit; busy low afterwards.
2. msb_first=1, sin sequence 0,1,0,1,0,0,1,0,1,1 -> dout=8'hA5. Repeat with msb_first toggled after the start bit -> still 8'hA5 (direction latched at start).
3. After 0xA5 is received, send frame 0x3C with stop bit 0 and hold sin=0 for 5 cycles, then sin=1 -> frame_err pulses once; dout stays 8'hA5; no dout_valid; busy stays high until the sin=1 sample. A following frame 0x5A is then received correctly.
4. en high only every 4th cycle, with sin toggling randomly on the other cycles and frame 0xC3 driven on the en cycles -> dout=8'hC3, dout_valid one cycle; glitches ignored.
5. Assert rst_n=0 asynchronously after the 4th data bit of frame 0xFF -> all outputs 0 immediately, without a clk edge. After release, frame 0x81 -> dout=8'h81.
6. With SERIAL_FRAME_RX_PARITY_EN defined:
   - 0xA5 with parity bit 0 -> dout_valid, parity_err=0.
   - 0xA5 with parity bit 1 -> dout_valid and parity_err pulse in the same cycle.
   - Frame length is 11 cycles.
